// File: rtl/sevseg_digit_counter.sv
// Run/pause single-digit counter feeding a seven-segment decoder on A..D.
// Optional SEVSEG_DIGIT_UPDOWN_EN adds an up_dn input for down counting.
module sevseg_digit_counter #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned MAX_DIGIT = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_ss,
    input  logic clr,
`ifdef SEVSEG_DIGIT_UPDOWN_EN
    input  logic up_dn,
`endif
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic tick,
    output logic carry,
    output logic running
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    DIGIT_MAX  = 4'(MAX_DIGIT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic          sync0_q, sync1_q, edge_q;
    logic          ss_pulse;
    logic          count_up;
    logic [1:0]    state_q, state_nx;
    logic [PW-1:0] presc_q, presc_nx;
    logic [3:0]    digit_q, digit_nx;
    logic          tick_nx, carry_nx, running_nx;

`ifdef SEVSEG_DIGIT_UPDOWN_EN
    assign count_up = up_dn;
`else
    assign count_up = 1'b1;
`endif

    // Button synchroniser and rising-edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync0_q <= btn_ss;
            sync1_q <= sync0_q;
            edge_q  <= sync1_q;
        end
    end

    assign ss_pulse = sync1_q & ~edge_q;

    // State, prescaler, digit and output flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            digit_q <= '0;
            tick    <= 1'b0;
            carry   <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_nx;
            presc_q <= presc_nx;
            digit_q <= digit_nx;
            tick    <= tick_nx;
            carry   <= carry_nx;
            running <= running_nx;
        end
    end

    // Clear beats the button; a button press on a step edge still lets the step land
    always_comb begin
        state_nx = state_q;
        presc_nx = presc_q;
        digit_nx = digit_q;
        tick_nx  = 1'b0;
        carry_nx = 1'b0;
        if (clr) begin
            state_nx = ST_IDLE;
            presc_nx = '0;
            digit_nx = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_nx = '0;
                    digit_nx = '0;
                    if (ss_pulse) state_nx = ST_RUN;
                end
                ST_RUN: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_nx = '0;
                        tick_nx  = 1'b1;
                        if (count_up) begin
                            if (digit_q >= DIGIT_MAX) begin
                                digit_nx = '0;
                                carry_nx = 1'b1;
                            end else begin
                                digit_nx = digit_q + 4'd1;
                            end
                        end else begin
                            if (digit_q == 4'd0 || digit_q > DIGIT_MAX) begin
                                digit_nx = DIGIT_MAX;
                                carry_nx = 1'b1;
                            end else begin
                                digit_nx = digit_q - 4'd1;
                            end
                        end
                    end else begin
                        presc_nx = presc_q + PW'(1);
                    end
                    if (ss_pulse) state_nx = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (ss_pulse) state_nx = ST_RUN;
                end
                default: begin
                    state_nx = ST_IDLE;
                    presc_nx = '0;
                    digit_nx = '0;
                end
            endcase
        end
        running_nx = (state_nx == ST_RUN);
    end

    assign A = digit_q[0];
    assign B = digit_q[1];
    assign C = digit_q[2];
    assign D = digit_q[3];

endmodule

// File: tb/tb_sevseg_digit_counter.sv
// Directed bench for sevseg_digit_counter with TICK_DIV=4, MAX_DIGIT=9.
module tb_sevseg_digit_counter;

    logic clk = 1'b0;
    logic rst_n, btn_ss, clr;
    logic A, B, C, D, tick, carry, running;
`ifdef SEVSEG_DIGIT_UPDOWN_EN
    logic up_dn;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sevseg_digit_counter #(.TICK_DIV(4), .MAX_DIGIT(9)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_ss(btn_ss),
        .clr(clr),
`ifdef SEVSEG_DIGIT_UPDOWN_EN
        .up_dn(up_dn),
`endif
        .A(A), .B(B), .C(C), .D(D),
        .tick(tick),
        .carry(carry),
        .running(running)
    );

    function automatic logic [3:0] dig();
        return {D, C, B, A};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_ss = 1'b1; clr = 1'b0;
        step(); step();
        n_checks++; if (dig() !== 4'd0) $display("FAIL reset_digit got=%0d exp=0", dig()); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", tick); else n_pass++;
        n_checks++; if (carry !== 1'b0) $display("FAIL reset_carry got=%b exp=0", carry); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL reset_running got=%b exp=0", running); else n_pass++;
        btn_ss = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step(); step();
        n_checks++; if (running !== 1'b0) $display("FAIL reset_no_start got=%b exp=0", running); else n_pass++;
    endtask

    task automatic test_start_wrap();
        int ticks = 0;
        int carries = 0;
        int bad_gap = 0;
        btn_ss = 1'b1;
        step(); step();
        n_checks++; if (running !== 1'b0) $display("FAIL start_early got=%b exp=0", running); else n_pass++;
        step();
        n_checks++; if (running !== 1'b1) $display("FAIL start_running got=%b exp=1", running); else n_pass++;
        for (int k = 1; k <= 10; k++) begin
            for (int j = 0; j < 3; j++) begin
                step();
                if (tick !== 1'b0 || carry !== 1'b0 || dig() !== 4'((k - 1) % 10)) bad_gap++;
            end
            step();
            if (tick === 1'b1) ticks++;
            if (carry === 1'b1) carries++;
            n_checks++;
            if (dig() !== 4'(k % 10)) $display("FAIL wrap_digit step=%0d got=%0d exp=%0d", k, dig(), k % 10);
            else n_pass++;
            n_checks++;
            if (carry !== (k == 10)) $display("FAIL wrap_carry step=%0d got=%b exp=%b", k, carry, (k == 10));
            else n_pass++;
        end
        n_checks++; if (ticks !== 10) $display("FAIL wrap_tick_count got=%0d exp=10", ticks); else n_pass++;
        n_checks++; if (carries !== 1) $display("FAIL wrap_carry_count got=%0d exp=1", carries); else n_pass++;
        n_checks++; if (bad_gap !== 0) $display("FAIL wrap_gap_cycles got=%0d exp=0", bad_gap); else n_pass++;
    endtask

    task automatic test_pause_resume();
        int bad = 0;
        btn_ss = 1'b0;
        step(); step(); step();
        btn_ss = 1'b1;
        step();
        n_checks++; if (dig() !== 4'd1 || tick !== 1'b1) $display("FAIL pause_pre_step got=%0d/%b exp=1/1", dig(), tick); else n_pass++;
        step();
        n_checks++; if (running !== 1'b1) $display("FAIL pause_still_run got=%b exp=1", running); else n_pass++;
        step();
        n_checks++; if (running !== 1'b0) $display("FAIL pause_entered got=%b exp=0", running); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dig() !== 4'd1 || running !== 1'b0 || tick !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL pause_hold bad_cycles=%0d exp=0", bad); else n_pass++;
        btn_ss = 1'b0;
        step(); step(); step();
        btn_ss = 1'b1;
        step(); step(); step();
        n_checks++; if (running !== 1'b1 || dig() !== 4'd1) $display("FAIL resume_run got=%b/%0d exp=1/1", running, dig()); else n_pass++;
        step();
        n_checks++; if (tick !== 1'b0 || dig() !== 4'd1) $display("FAIL resume_first_edge got=%b/%0d exp=0/1", tick, dig()); else n_pass++;
        step();
        n_checks++; if (tick !== 1'b1 || dig() !== 4'd2) $display("FAIL resume_step got=%b/%0d exp=1/2", tick, dig()); else n_pass++;
    endtask

    task automatic test_clear();
        int bad = 0;
        for (int i = 0; i < 12; i++) step();
        n_checks++; if (dig() !== 4'd5) $display("FAIL clear_pre_digit got=%0d exp=5", dig()); else n_pass++;
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++; if (dig() !== 4'd0 || running !== 1'b0 || tick !== 1'b0) $display("FAIL clear_now got=%0d/%b/%b exp=0/0/0", dig(), running, tick); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step();
            if (running !== 1'b0 || dig() !== 4'd0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL clear_no_restart bad_cycles=%0d exp=0", bad); else n_pass++;
        btn_ss = 1'b0;
        step(); step(); step();
        btn_ss = 1'b1;
        step(); step(); step();
        n_checks++; if (running !== 1'b1) $display("FAIL clear_restart got=%b exp=1", running); else n_pass++;
    endtask

    task automatic test_collision();
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 1) btn_ss = 1'b0;
            if (i == 13) btn_ss = 1'b1;
            if (i == 12) begin
                n_checks++;
                if (dig() !== 4'd3) $display("FAIL collide_pre got=%0d exp=3", dig()); else n_pass++;
            end
        end
        n_checks++; if (dig() !== 4'd4) $display("FAIL collide_digit got=%0d exp=4", dig()); else n_pass++;
        n_checks++; if (tick !== 1'b1) $display("FAIL collide_tick got=%b exp=1", tick); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL collide_running got=%b exp=0", running); else n_pass++;
        step(); step(); step(); step(); step();
        n_checks++; if (dig() !== 4'd4 || tick !== 1'b0) $display("FAIL collide_held got=%0d/%b exp=4/0", dig(), tick); else n_pass++;
    endtask

`ifdef SEVSEG_DIGIT_UPDOWN_EN
    task automatic test_down();
        logic [3:0] exp_d [3] = '{4'd9, 4'd8, 4'd7};
        clr = 1'b1;
        step();
        clr = 1'b0;
        up_dn = 1'b0;
        btn_ss = 1'b0;
        step(); step(); step();
        btn_ss = 1'b1;
        step(); step(); step();
        for (int k = 0; k < 3; k++) begin
            step(); step(); step(); step();
            n_checks++;
            if (dig() !== exp_d[k]) $display("FAIL down_digit step=%0d got=%0d exp=%0d", k, dig(), exp_d[k]);
            else n_pass++;
            n_checks++;
            if (carry !== (k == 0)) $display("FAIL down_carry step=%0d got=%b exp=%b", k, carry, (k == 0));
            else n_pass++;
        end
        up_dn = 1'b1;
        step(); step(); step(); step();
        n_checks++; if (dig() !== 4'd8) $display("FAIL down_to_up got=%0d exp=8", dig()); else n_pass++;
    endtask
`endif

    initial begin
`ifdef SEVSEG_DIGIT_UPDOWN_EN
        up_dn = 1'b1;
`endif
        test_reset();
        test_start_wrap();
        test_pause_resume();
        test_clear();
        test_collision();
`ifdef SEVSEG_DIGIT_UPDOWN_EN
        test_down();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
